// File: rtl/booth_mul_seq.sv
// booth_mul_seq: multi-cycle radix-4 Booth multiplier with start/busy/done handshake and HI/LO product
module booth_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             overflow
);
  localparam int NDIG = WIDTH / 2 + 1;
  localparam int AW = 2 * WIDTH + 2;
  localparam int CW = $clog2(NDIG);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] m_q, m_d, acc_q, acc_d, mult;
  logic [WIDTH+2:0] bsh_q, bsh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic sgn_q, sgn_d, ovf_q, ovf_d, last;
  logic [2:0] trip;
  always_comb begin
    trip = bsh_q[2:0];
    mult = (trip == 3'b001 || trip == 3'b010) ? m_q :
           (trip == 3'b011) ? m_q << 1 :
           (trip == 3'b100) ? -(m_q << 1) :
           (trip == 3'b101 || trip == 3'b110) ? -m_q : '0;
    last = cnt_q == CW'(NDIG - 1);
    state_d = state_q;
    m_d = m_q;
    acc_d = acc_q;
    bsh_d = bsh_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    lo_d = lo_q;
    sgn_d = sgn_q;
    ovf_d = ovf_q;
    if (state_q == RUN) begin
      acc_d = acc_q + mult;
      m_d = m_q << 2;
      bsh_d = bsh_q >> 2;
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        state_d = DONE;
        {hi_d, lo_d} = acc_d[2*WIDTH-1:0];
        ovf_d = sgn_q ? hi_d != {WIDTH{lo_d[WIDTH-1]}} : hi_d != '0;
      end
    end else begin
      state_d = start ? RUN : IDLE;
      if (start) begin
        sgn_d = signed_op;
        m_d = {{(AW-WIDTH){signed_op & a[WIDTH-1]}}, a};
        bsh_d = {{2{signed_op & b[WIDTH-1]}}, b, 1'b0};
        acc_d = '0;
        cnt_d = '0;
      end
    end
  end
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      m_q <= '0;
      acc_q <= '0;
      bsh_q <= '0;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      sgn_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q <= m_d;
      acc_q <= acc_d;
      bsh_q <= bsh_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      sgn_q <= sgn_d;
      ovf_q <= ovf_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign hi = hi_q;
  assign lo = lo_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: directed and random checks of booth_mul_seq at WIDTH 32 and 8 against an arithmetic model
module tb_booth_mul_seq;
  logic clock = 0, clear_n = 1, start = 0, sg = 0;
  logic [31:0] a = 0, b = 0;
  int sel_w = 32;
  int checks = 0, errors = 0;
  longint cyc = 0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;
  logic busy32, done32, ovf32, busy8, done8, ovf8, st32, st8;
  logic [31:0] hi32, lo32;
  logic [7:0] hi8, lo8;
  logic bs, dn, ov;
  logic [31:0] hs, ls;
  assign st32 = start && sel_w == 32;
  assign st8 = start && sel_w == 8;
  booth_mul_seq #(.WIDTH(32)) d32 (.clock(clock), .clear_n(clear_n), .start(st32), .signed_op(sg),
    .a(a), .b(b), .busy(busy32), .done(done32), .hi(hi32), .lo(lo32), .overflow(ovf32));
  booth_mul_seq #(.WIDTH(8)) d8 (.clock(clock), .clear_n(clear_n), .start(st8), .signed_op(sg),
    .a(a[7:0]), .b(b[7:0]), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .overflow(ovf8));
  always_comb begin
    bs = sel_w == 32 ? busy32 : busy8;
    dn = sel_w == 32 ? done32 : done8;
    ov = sel_w == 32 ? ovf32 : ovf8;
    hs = sel_w == 32 ? hi32 : {24'd0, hi8};
    ls = sel_w == 32 ? lo32 : {24'd0, lo8};
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model(input int w, input logic s, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] eh, output logic [31:0] el, output logic eo);
    longint xv, yv, p, mask;
    logic [63:0] pu;
    mask = (longint'(1) << w) - 1;
    xv = longint'({32'd0, x}) & mask;
    yv = longint'({32'd0, y}) & mask;
    if (s && xv[w-1]) xv -= longint'(1) << w;
    if (s && yv[w-1]) yv -= longint'(1) << w;
    p = xv * yv;
    pu = p;
    eo = s ? (p < -(longint'(1) << (w - 1)) || p >= (longint'(1) << (w - 1))) : (pu >= (64'd1 << w));
    el = 32'(p & mask);
    eh = 32'((p >>> w) & mask);
  endtask
  task automatic op(input int w, input logic s, input logic [31:0] x, input logic [31:0] y,
                    output int lat, output logic chg);
    logic [31:0] h0, l0;
    @(negedge clock);
    sel_w = w;
    sg = s;
    a = x;
    b = y;
    start = 1;
    @(posedge clock);
    @(negedge clock);
    start = 0;
    a = $urandom;
    b = $urandom;
    sg = ~s;
    h0 = hs;
    l0 = ls;
    chk("busy_in_run", bs, 1);
    lat = 0;
    chg = 0;
    while (lat < 60) begin
      if (dn) break;
      if (hs !== h0 || ls !== l0) chg = 1;
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
  endtask
  task automatic verify(input int w, input logic s, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] eh, el;
    logic eo, chg;
    int lat;
    model(w, s, x, y, eh, el, eo);
    op(w, s, x, y, lat, chg);
    chk("latency", lat, w / 2 + 1);
    chk("hi", hs, eh);
    chk("lo", ls, el);
    chk("overflow", ov, eo);
    chk("hold_during_run", chg, 0);
  endtask
  initial begin
    int nd;
    longint t1, t2;
    #1 clear_n = 0;
    #1;
    chk("rst_busy", busy32, 0);
    chk("rst_done", done32, 0);
    chk("rst_hi", hi32, 0);
    chk("rst_lo", lo32, 0);
    chk("rst_ovf", ovf32, 0);
    chk("rst_out8", {busy8, done8, hi8, lo8, ovf8}, 0);
    repeat (2) @(negedge clock);
    clear_n = 1;
    verify(32, 1, 32'hFFFFFFF9, 32'd3);
    chk("neg7x3_hi", hs, 32'hFFFFFFFF);
    chk("neg7x3_lo", ls, 32'hFFFFFFEB);
    chk("neg7x3_ovf", ov, 0);
    @(negedge clock);
    sel_w = 32;
    sg = 1;
    a = 5;
    b = 6;
    start = 1;
    @(posedge clock);
    @(negedge clock);
    start = 0;
    repeat (3) @(posedge clock);
    #2 clear_n = 0;
    #1;
    chk("midrun_rst_busy", busy32, 0);
    chk("midrun_rst_done", done32, 0);
    chk("midrun_rst_hilo", {hi32, lo32}, 0);
    chk("midrun_rst_ovf", ovf32, 0);
    @(negedge clock);
    clear_n = 1;
    nd = 0;
    repeat (30) begin
      @(negedge clock);
      if (done32) nd++;
    end
    chk("no_done_after_rst", nd, 0);
    verify(32, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("uones_hilo", {hs, ls}, 64'hFFFFFFFE_00000001);
    chk("uones_ovf", ov, 1);
    verify(32, 1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("sones_hilo", {hs, ls}, 64'h00000000_00000001);
    chk("sones_ovf", ov, 0);
    verify(32, 1, 32'h80000000, 32'h80000000);
    chk("minmin_hilo", {hs, ls}, 64'h40000000_00000000);
    chk("minmin_ovf", ov, 1);
    verify(32, 1, 32'h00010000, 32'h00010000);
    chk("2p16sq_hilo", {hs, ls}, 64'h00000001_00000000);
    chk("2p16sq_ovf", ov, 1);
    verify(32, 1, 32'd0, 32'h80000000);
    chk("zero_hilo", {hs, ls, 31'd0, ov}, 0);
    verify(8, 1, 32'h80, 32'h80);
    verify(8, 0, 32'hFF, 32'hFF);
    verify(8, 1, 32'h7F, 32'h80);
    verify(8, 0, 32'h00, 32'hA5);
    @(negedge clock);
    sel_w = 32;
    sg = 0;
    a = 2;
    b = 3;
    start = 1;
    @(posedge clock);
    @(negedge clock);
    a = 4;
    b = 5;
    nd = 0;
    while (!dn && nd < 60) begin
      @(negedge clock);
      nd++;
    end
    t1 = cyc;
    chk("b2b_first_lo", ls, 6);
    @(posedge clock);
    @(negedge clock);
    start = 0;
    chk("b2b_busy_after_done", {bs, dn}, 2'b10);
    nd = 0;
    while (!dn && nd < 60) begin
      @(negedge clock);
      nd++;
    end
    t2 = cyc;
    chk("b2b_spacing", t2 - t1, 18);
    chk("b2b_second_lo", ls, 20);
    @(negedge clock);
    a = 1;
    b = 1;
    start = 1;
    @(posedge clock);
    @(negedge clock);
    start = 0;
    repeat (4) @(negedge clock);
    start = 1;
    a = 9;
    @(negedge clock);
    start = 0;
    repeat (3) @(negedge clock);
    start = 1;
    @(negedge clock);
    start = 0;
    nd = 0;
    repeat (30) begin
      @(negedge clock);
      if (done32) nd++;
    end
    chk("midrun_start_ignored", nd, 1);
    chk("midrun_start_lo", lo32, 1);
    for (int i = 0; i < 1500; i++) verify(32, 1'($urandom), $urandom, $urandom);
    for (int i = 0; i < 1500; i++) verify(8, 1'($urandom), $urandom, $urandom);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
